// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the register file. After reset it clears
//   every register (one per cycle). It then arbitrates the write port between
//   core writeback and an IO/debug requester, briefly stalling the core when
//   the IO request has lost arbitration MAX_WAIT times in a row.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   core_wb_*      core writeback request (en/addr/data), valid every cycle
//   io_req/addr/data  IO write request, held by the requester until io_ack
//   io_ack         one-cycle pulse, aligned with the rf write it caused
//   core_stall     combinational; core must not commit or advance while high
//   ready          clear sequence complete, register file contents valid
//   rf_we/waddr/wdata  registered register-file write port
module regfile_wb_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_wb_en,
   input  logic [ADDR_W-1:0] core_wb_addr,
   input  logic [DATA_W-1:0] core_wb_data,
   input  logic              io_req,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_data,
   output logic              io_ack,
   output logic              core_stall,
   output logic              ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_WAIT);
   localparam logic [ADDR_W-1:0] IDX_LAST = '1;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_idx_q;
   logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
   logic                ready_q;
   logic                io_ack_q;
   logic                rf_we_q;
   logic [ADDR_W-1:0]   rf_waddr_q;
   logic [DATA_W-1:0]   rf_wdata_q;

   logic io_pending;
   logic force_io;
   logic grant_io;
   logic grant_core;

   // Arbitration only opens once ready is registered, i.e. one cycle after the
   // last clear write, so the clear never overlaps a functional write and the
   // core stays stalled for the whole sequence.
   // A request still high during its own ack cycle has already been served.
   assign io_pending = io_req && !io_ack_q;
   assign force_io   = ready_q && io_pending && (starve_cnt_q == CNT_MAX);
   assign grant_core = ready_q && !force_io && core_wb_en;
   assign grant_io   = ready_q && (force_io || (!core_wb_en && io_pending));
   assign core_stall = !ready_q || force_io;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!ready_q || !io_req || grant_io) begin
         starve_cnt_d = '0;
      end else if (io_pending && grant_core && (starve_cnt_q != CNT_MAX)) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         clr_idx_q    <= '0;
         starve_cnt_q <= '0;
         ready_q      <= 1'b0;
         io_ack_q     <= 1'b0;
         rf_we_q      <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         unique case (state_q)
            ST_CLEAR: begin
               rf_we_q    <= 1'b1;
               rf_waddr_q <= clr_idx_q;
               rf_wdata_q <= '0;
               io_ack_q   <= 1'b0;
               clr_idx_q  <= clr_idx_q + 1'b1;
               if (clr_idx_q == IDX_LAST) begin
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               ready_q  <= 1'b1;
               io_ack_q <= grant_io;
               // x0 is hard-wired to zero: the request is consumed but the
               // write enable is suppressed.
               if (grant_io) begin
                  rf_we_q    <= (io_addr != '0);
                  rf_waddr_q <= io_addr;
                  rf_wdata_q <= io_data;
               end else if (grant_core) begin
                  rf_we_q    <= (core_wb_addr != '0);
                  rf_waddr_q <= core_wb_addr;
                  rf_wdata_q <= core_wb_data;
               end else begin
                  rf_we_q <= 1'b0;
               end
            end
            default: state_q <= ST_CLEAR;
         endcase
      end
   end

   assign io_ack   = io_ack_q;
   assign ready    = ready_q;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: expected write-port words are pushed to a
// scoreboard queue as stimulus is driven and popped after each clock edge.
module tb_regfile_wb_arbiter;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              core_wb_en;
   logic [ADDR_W-1:0] core_wb_addr;
   logic [DATA_W-1:0] core_wb_data;
   logic              io_req;
   logic [ADDR_W-1:0] io_addr;
   logic [DATA_W-1:0] io_data;
   logic              io_ack;
   logic              core_stall;
   logic              ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              ack;
   } wr_t;

   wr_t sb_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   regfile_wb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .core_wb_en  (core_wb_en),
      .core_wb_addr(core_wb_addr),
      .core_wb_data(core_wb_data),
      .io_req      (io_req),
      .io_addr     (io_addr),
      .io_data     (io_data),
      .io_ack      (io_ack),
      .core_stall  (core_stall),
      .ready       (ready),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic wr_t obs();
      return '{we: rf_we, addr: rf_waddr, data: rf_wdata, ack: io_ack};
   endfunction

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_wb_en   = 1'b0;
      core_wb_addr = '0;
      core_wb_data = '0;
      io_req       = 1'b0;
      io_addr      = '0;
      io_data      = '0;
   endtask

   // Reset held for two edges, outputs must show reset values.
   task automatic test_reset();
      wr_t o;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      o = obs();
      n_tests++;
      if (o !== wr_t'(0) || ready !== 1'b0 || core_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_values: got port=%h ready=%b stall=%b, want port=0 ready=0 stall=1",
                  o, ready, core_stall);
      end
   endtask

   // Release reset with no requests; cycles 1..32 carry the clear writes.
   task automatic test_clear();
      wr_t e, o;
      for (int k = 0; k < 32; k++) sb_q.push_back('{we: 1'b1, addr: ADDR_W'(k), data: '0, ack: 1'b0});
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         e = sb_q.pop_front();
         o = obs();
         n_tests++;
         if (o !== e || core_stall !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_cycle_%0d: got port=%h stall=%b ready=%b, want port=%h stall=1 ready=0",
                     k, o, core_stall, ready, e);
         end
      end
      tick();
      n_tests++;
      if (ready !== 1'b1 || core_stall !== 1'b0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_done_cycle_33: got ready=%b stall=%b we=%b, want 1 0 0",
                  ready, core_stall, rf_we);
      end
   endtask

   // Single core writeback, then an idle cycle holding addr/data.
   task automatic test_core_write();
      wr_t e, o;
      core_wb_en   = 1'b1;
      core_wb_addr = 5'd5;
      core_wb_data = 32'hDEADBEEF;
      sb_q.push_back('{we: 1'b1, addr: 5'd5, data: 32'hDEADBEEF, ack: 1'b0});
      tick();
      idle_inputs();
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL core_write: got %h, want %h", o, e);
      end
      sb_q.push_back('{we: 1'b0, addr: 5'd5, data: 32'hDEADBEEF, ack: 1'b0});
      tick();
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL core_idle_hold: got %h, want %h", o, e);
      end
   endtask

   // Core writes every cycle; IO request wins after MAX_WAIT losses.
   task automatic test_starvation();
      wr_t e, o;
      io_req  = 1'b1;
      io_addr = 5'd7;
      io_data = 32'h12345678;
      core_wb_en   = 1'b1;
      core_wb_addr = 5'd3;
      for (int i = 0; i < MAX_WAIT; i++) begin
         core_wb_data = 32'h100 + i;
         #1;
         n_tests++;
         if (core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_stall_early_%0d: got %b, want 0", i, core_stall);
         end
         sb_q.push_back('{we: 1'b1, addr: 5'd3, data: 32'h100 + i, ack: 1'b0});
         tick();
         e = sb_q.pop_front();
         o = obs();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL starve_core_win_%0d: got %h, want %h", i, o, e);
         end
      end
      core_wb_data = 32'hBAD0BAD0;
      #1;
      n_tests++;
      if (core_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL starve_stall_forced: got %b, want 1", core_stall);
      end
      sb_q.push_back('{we: 1'b1, addr: 5'd7, data: 32'h12345678, ack: 1'b1});
      tick();
      io_req = 1'b0;
      core_wb_data = 32'h200;
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL starve_io_write: got %h, want %h", o, e);
      end
      #1;
      n_tests++;
      if (core_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL starve_stall_release: got %b, want 0", core_stall);
      end
      sb_q.push_back('{we: 1'b1, addr: 5'd3, data: 32'h200, ack: 1'b0});
      tick();
      idle_inputs();
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL starve_after_ack: got %h, want %h", o, e);
      end
   endtask

   // Writes to x0 from both sources: consumed, never written, no stall.
   task automatic test_x0();
      wr_t e, o;
      io_req  = 1'b1;
      io_addr = 5'd0;
      io_data = 32'hFFFFFFFF;
      sb_q.push_back('{we: 1'b0, addr: 5'd0, data: 32'hFFFFFFFF, ack: 1'b1});
      tick();
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL io_x0: got %h, want %h", o, e);
      end
      // io_req still high during its ack cycle must not be re-granted.
      sb_q.push_back('{we: 1'b0, addr: 5'd0, data: 32'hFFFFFFFF, ack: 1'b0});
      tick();
      io_req = 1'b0;
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL io_no_regrant: got %h, want %h", o, e);
      end
      core_wb_en   = 1'b1;
      core_wb_addr = 5'd0;
      core_wb_data = 32'h55AA55AA;
      #1;
      n_tests++;
      if (core_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL core_x0_stall: got %b, want 0", core_stall);
      end
      sb_q.push_back('{we: 1'b0, addr: 5'd0, data: 32'h55AA55AA, ack: 1'b0});
      tick();
      idle_inputs();
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL core_x0: got %h, want %h", o, e);
      end
   endtask

   // Reset asserted when clr_idx==10; clear restarts and ready rises 33 later.
   task automatic test_reset_mid_clear();
      wr_t e, o;
      int  n;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      n_tests++;
      if (rf_waddr !== 5'd9) begin
         n_fail++;
         $display("FAIL mid_clear_idx: got %0d, want 9", rf_waddr);
      end
      reset = 1'b1;
      tick();
      o = obs();
      n_tests++;
      if (o !== wr_t'(0) || ready !== 1'b0 || core_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_clear_reset: got port=%h ready=%b stall=%b, want 0 0 1", o, ready, core_stall);
      end
      reset = 1'b0;
      sb_q.push_back('{we: 1'b1, addr: 5'd0, data: '0, ack: 1'b0});
      tick();
      n = 1;
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL restart_idx0: got %h, want %h", o, e);
      end
      while (ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_tests++;
      if (n != 33) begin
         n_fail++;
         $display("FAIL ready_latency: got %0d cycles, want 33", n);
      end
   endtask

   // IO request held through reset and clear: served only after ready.
   task automatic test_io_during_clear();
      wr_t e, o;
      int  bad_ack;
      reset   = 1'b1;
      io_req  = 1'b1;
      io_addr = 5'd9;
      io_data = 32'hCAFE0009;
      tick();
      reset = 1'b0;
      bad_ack = 0;
      for (int k = 1; k <= 33; k++) begin
         tick();
         if (io_ack !== 1'b0) bad_ack++;
      end
      n_tests++;
      if (bad_ack != 0 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL io_clear_ignored: got %0d acks ready=%b, want 0 acks ready=1", bad_ack, ready);
      end
      sb_q.push_back('{we: 1'b1, addr: 5'd9, data: 32'hCAFE0009, ack: 1'b1});
      tick();
      io_req = 1'b0;
      e = sb_q.pop_front();
      o = obs();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL io_after_clear: got %h, want %h", o, e);
      end
      tick();
      n_tests++;
      if (io_ack !== 1'b0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL io_ack_single: got ack=%b we=%b, want 0 0", io_ack, rf_we);
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_core_write();
      test_starvation();
      test_x0();
      test_reset_mid_clear();
      test_io_during_clear();
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single write port of the 32x32 register file.
- After reset, it sequences a hardware clear of all 32 registers, one register per cycle.
- During normal operation it arbitrates the write port between core writeback and an IO/debug requester (UART loader, test host).
- A starvation guard briefly stalls the core so the IO requester always makes progress.

Parameters:
ADDR_W, 5, register index width
DATA_W, 32, register data width
MAX_WAIT, 4, cycles an IO request may lose arbitration before the core is stalled for it

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
core_wb_en  in  1  core writeback request this cycle
core_wb_addr  in  ADDR_W  core destination register
core_wb_data  in  DATA_W  core writeback data
io_req  in  1  IO write request; held until io_ack
io_addr  in  ADDR_W  IO destination register
io_data  in  DATA_W  IO write data
io_ack  out  1  one-cycle pulse: IO request consumed
core_stall  out  1  combinational; core must not commit a writeback or advance PC while high
ready  out  1  clear sequence complete; register file valid
rf_we  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write address (registered)
rf_wdata  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (clk edge with reset=1):
  - State, counter and index: state=CLEAR, clr_idx=0, starve_cnt=0.
  - Registered outputs: rf_we=0, rf_waddr=0, rf_wdata=0, io_ack=0, ready=0.
  - core_stall=1 while in CLEAR.
- CLEAR state:
  - Each cycle it registers rf_we=1, rf_waddr=clr_idx, rf_wdata=0, then increments clr_idx.
  - Counting cycle 1 as the first clk edge with reset=0, clear writes to indices 0..31 appear on the rf_* outputs in cycles 1..32.
  - On the edge that registers index 31, state becomes RUN. ready=1 and core_stall=0 from cycle 33.
  - io_req is ignored in CLEAR: no grant, starve_cnt held at 0.
  - core_wb_en is ignored in CLEAR; core_stall=1 covers it.
- RUN state, grant decided combinationally each cycle:
  - force_io = io_req && !io_ack && starve_cnt==MAX_WAIT.
  - core_stall = force_io.
  - Priority: force_io -> IO; else core_wb_en -> core; else io_req && !io_ack -> IO; else idle.
- Grant latency: one cycle.
  - The granted source's addr/data appear on rf_waddr/rf_wdata on the next edge.
  - rf_we=1 on that same edge unless the granted addr==0. x0 is never written, but the request is still consumed.
  - With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- io_ack:
  - Registered; 1 in the cycle after an IO grant, same cycle as the corresponding rf write.
  - Never high two consecutive cycles.
  - io_req still high during the ack cycle is not re-granted.
- starve_cnt:
  - Cleared when io_req=0, on an IO grant, or in CLEAR.
  - Otherwise increments when io_req && !io_ack && the core wins.
  - Saturates at MAX_WAIT.
- Core writes to x0: no rf write, no stall.
- Reset mid-CLEAR or mid-RUN: immediate return to reset values. A pending IO request is dropped with no ack; the requester must hold io_req and is served after the new clear completes.
- ready stays 1 until the next reset.

Test Plan:
1. Release reset with no requests -> cycles 1..32: rf_we=1, rf_waddr=0..31, rf_wdata=0, core_stall=1, ready=0. Cycle 33: ready=1, core_stall=0, rf_we=0.
2. After ready, core_wb_en=1, addr=5, data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. io_ack stays 0.
3. Core writes every cycle (addr 3); io_req=1, io_addr=7, io_data=0x12345678 held -> core wins 4 cycles. Fifth cycle: core_stall=1. Next cycle: rf write addr 7 data 0x12345678, io_ack=1 for exactly one cycle; core_stall=0 again.
4. Core idle; io_req addr=0 data=0xFFFFFFFF -> next cycle io_ack=1, rf_we=0.
5. Assert reset when clr_idx=10 -> all outputs at reset values. Clear restarts from index 0 and ready rises 33 cycles after the release.
6. io_req held during CLEAR -> no io_ack before ready. First RUN cycle with core idle: granted; rf write and io_ack in the following cycle.
